// File: rtl/dmem_pkg.sv
// Shared types for the data-memory port: funct3 size codes, FSM states and
// the alignment helper used when DMEM_MISALIGN_TRAP_EN is defined.
package dmem_pkg;

    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } mem_op_e;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dmem_state_e;

    // Halfword accesses need addr[0] clear; word accesses need addr[1:0] clear.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        if (funct3 == MEM_H || funct3 == MEM_HU)
            mis = addr_lo[0];
        else if (funct3 == MEM_W)
            mis = |addr_lo;
        return mis;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane logic: load extract/extend and store byte-enable/data
// replication; op_ok flags funct3 codes that are legal for the access type.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]                funct3,
    input  logic                      is_store,
    input  logic [1:0]                addr_lo,
    input  logic [31:0]               mem_word,
    input  logic [31:0]               wdata,
    output logic                      op_ok,
    output logic [31:0]               load_data,
    output logic [BYTES_PER_WORD-1:0] byte_en,
    output logic [31:0]               store_word
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign ld_byte = mem_word[{addr_lo, 3'b000} +: 8];
    assign ld_half = addr_lo[1] ? mem_word[31:16] : mem_word[15:0];

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        op_ok      = 1'b0;
        load_data  = '0;
        byte_en    = '0;
        store_word = '0;
        if (is_store) begin
            case (funct3)
                MEM_B: begin
                    op_ok      = 1'b1;
                    byte_en    = 4'b0001 << addr_lo;
                    store_word = {4{wdata[7:0]}};
                end
                MEM_H: begin
                    op_ok      = 1'b1;
                    byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
                    store_word = {2{wdata[15:0]}};
                end
                MEM_W: begin
                    op_ok      = 1'b1;
                    byte_en    = 4'b1111;
                    store_word = wdata;
                end
                default: op_ok = 1'b0;
            endcase
        end else begin
            case (funct3)
                MEM_B:  begin op_ok = 1'b1; load_data = {{24{ld_byte[7]}}, ld_byte}; end
                MEM_H:  begin op_ok = 1'b1; load_data = {{16{ld_half[15]}}, ld_half}; end
                MEM_W:  begin op_ok = 1'b1; load_data = mem_word; end
                MEM_BU: begin op_ok = 1'b1; load_data = {24'd0, ld_byte}; end
                MEM_HU: begin op_ok = 1'b1; load_data = {16'd0, ld_half}; end
                default: op_ok = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/dmem_port.sv
// Single-outstanding data-memory port with a fixed response delay.
// Optional macro DMEM_MISALIGN_TRAP_EN turns misaligned halfword/word accesses into errors.
module dmem_port
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_mask,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int         IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    dmem_state_e state, state_nxt;
    logic [3:0]  wait_cnt;
    logic        we_q;
    logic [31:0] addr_q, wdata_q;
    logic [2:0]  mask_q;

    logic [31:0] mem [DEPTH_WORDS] = '{default: '0};

    logic                      accept, enter_resp;
    logic                      cur_we, cur_err, in_range, misalign, op_ok;
    logic [31:0]               cur_addr, cur_wdata, mem_word, load_data, store_word;
    logic [2:0]                cur_mask;
    logic [IDX_W-1:0]          cur_idx;
    logic [BYTES_PER_WORD-1:0] byte_en;

    assign req_ready  = (state == IDLE) && rst_n;
    assign resp_valid = (state == RESP);
    assign accept     = req_valid && req_ready;

    // In IDLE the live request is decoded (store commit, zero-wait read);
    // afterwards the latched copy drives the read sampled when entering RESP.
    assign cur_we    = (state == IDLE) ? req_we    : we_q;
    assign cur_addr  = (state == IDLE) ? req_addr  : addr_q;
    assign cur_wdata = (state == IDLE) ? req_wdata : wdata_q;
    assign cur_mask  = (state == IDLE) ? req_mask  : mask_q;

    assign in_range = ~|cur_addr[31:IDX_W+2];
    assign cur_idx  = cur_addr[IDX_W+1:2];
    assign mem_word = mem[cur_idx];

`ifdef DMEM_MISALIGN_TRAP_EN
    assign misalign = is_misaligned(cur_mask, cur_addr[1:0]);
`else
    assign misalign = 1'b0;
`endif

    assign cur_err = !op_ok || !in_range || misalign;

    dmem_lane_align u_lane (
        .funct3     (cur_mask),
        .is_store   (cur_we),
        .addr_lo    (cur_addr[1:0]),
        .mem_word   (mem_word),
        .wdata      (cur_wdata),
        .op_ok      (op_ok),
        .load_data  (load_data),
        .byte_en    (byte_en),
        .store_word (store_word)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = (WAIT_CYCLES > 0) ? WAIT : RESP;
            WAIT:    if (wait_cnt == WAIT_LAST) state_nxt = RESP;
            RESP:    if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign enter_resp = (state_nxt == RESP) && (state != RESP);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            wait_cnt   <= 4'd0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= (state == WAIT) ? wait_cnt + 4'd1 : 4'd0;
            if (accept) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                mask_q  <= req_mask;
            end
            if (enter_resp) begin
                resp_rdata <= (cur_err || cur_we) ? 32'd0 : load_data;
                resp_err   <= cur_err;
            end
        end
    end

    // NOTE: the array has no reset; stores committed before a reset must survive it.
    always_ff @(posedge clk) begin
        if (accept && cur_we && !cur_err) begin
            for (int b = 0; b < BYTES_PER_WORD; b++) begin
                if (byte_en[b]) mem[cur_idx][8*b +: 8] <= store_word[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_port.sv
// Scoreboard bench for dmem_port: the driver queues expected responses, a
// monitor pops and compares on every response handshake.
module tb_dmem_port;

    localparam int WAIT_CYC = 1;
    localparam int DEPTH    = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_mask;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    dmem_port #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAIT_CYC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_mask   (req_mask),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: a response is consumed on the edge following a negedge that
    // sees resp_valid & resp_ready.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && resp_valid && resp_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_resp", 32'(resp_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("resp_rdata", resp_rdata, e.rdata);
                    check("resp_err", 32'(resp_err), 32'(e.err));
                end
            end
        end
    end

    // Entered and left at a negedge.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [2:0] mask, input logic [31:0] exp_rdata, input logic exp_err);
        int n;
        int lat;
        logic got;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check("req_ready_timeout", 32'(req_ready), 32'd1);
            return;
        end
        sb.push_back('{rdata: exp_rdata, err: exp_err});
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_mask  = mask;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            @(negedge clk);
            lat++;
            got = resp_valid;
        end
        check("resp_latency", 32'(lat), 32'(WAIT_CYC + 1));
        if (resp_ready) begin
            @(negedge clk);
            check("resp_done", 32'(resp_valid), 32'd0);
        end
    endtask

    initial begin
        logic [31:0] held;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        req_mask   = 3'd0;
        resp_ready = 1'b1;

        repeat (2) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_req_ready", 32'(req_ready), 32'd1);
        check("post_rst_resp_valid", 32'(resp_valid), 32'd0);
        check("post_rst_rdata", resp_rdata, 32'd0);
        check("post_rst_err", 32'(resp_err), 32'd0);

        // Word store/load, then sub-word store merge and signed/unsigned byte loads.
        do_req(1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 32'h0,        1'b0);
        do_req(1'b0, 32'h10, 32'h0,        3'b010, 32'hDEADBEEF, 1'b0);
        do_req(1'b1, 32'h11, 32'hAAAAAA55, 3'b000, 32'h0,        1'b0);
        do_req(1'b0, 32'h10, 32'h0,        3'b010, 32'hDEAD55EF, 1'b0);
        do_req(1'b0, 32'h13, 32'h0,        3'b000, 32'hFFFFFFDE, 1'b0);
        do_req(1'b0, 32'h13, 32'h0,        3'b100, 32'h000000DE, 1'b0);

        // Upper halfword store and halfword loads.
        do_req(1'b1, 32'h22, 32'h12348001, 3'b001, 32'h0,        1'b0);
        do_req(1'b0, 32'h22, 32'h0,        3'b001, 32'hFFFF8001, 1'b0);
        do_req(1'b0, 32'h22, 32'h0,        3'b101, 32'h00008001, 1'b0);
        do_req(1'b0, 32'h20, 32'h0,        3'b010, 32'h80010000, 1'b0);

        // Backpressure: response must hold while resp_ready is low.
        resp_ready = 1'b0;
        do_req(1'b0, 32'h12, 32'h0, 3'b000, 32'hFFFFFFAD, 1'b0);
        held = resp_rdata;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", 32'(resp_valid), 32'd1);
            check("stall_rdata", resp_rdata, held);
            check("stall_req_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk);
        #1 resp_ready = 1'b1;
        @(negedge clk);
        check("stall_last_valid", 32'(resp_valid), 32'd1);
        @(negedge clk);
        check("stall_released_valid", 32'(resp_valid), 32'd0);
        check("stall_released_ready", 32'(req_ready), 32'd1);

        // Errors: out-of-range, illegal store/load codes; memory must be unchanged.
        do_req(1'b0, 32'h100, 32'h0,        3'b010, 32'h0,        1'b1);
        do_req(1'b1, 32'h100, 32'h11111111, 3'b010, 32'h0,        1'b1);
        do_req(1'b1, 32'h10,  32'h12345678, 3'b011, 32'h0,        1'b1);
        do_req(1'b0, 32'h10,  32'h0,        3'b110, 32'h0,        1'b1);
        do_req(1'b0, 32'h10,  32'h0,        3'b010, 32'hDEAD55EF, 1'b0);

        // Last in-range word: zero from time 0, then written.
        do_req(1'b0, 32'hFC, 32'h0,        3'b010, 32'h0,        1'b0);
        do_req(1'b1, 32'hFC, 32'hCAFEF00D, 3'b010, 32'h0,        1'b0);
        do_req(1'b0, 32'hFC, 32'h0,        3'b010, 32'hCAFEF00D, 1'b0);

`ifdef DMEM_MISALIGN_TRAP_EN
        do_req(1'b0, 32'h12, 32'h0, 3'b010, 32'h0, 1'b1);
        do_req(1'b1, 32'h21, 32'h0, 3'b001, 32'h0, 1'b1);
        do_req(1'b0, 32'h20, 32'h0, 3'b010, 32'h80010000, 1'b0);
`else
        do_req(1'b0, 32'h12, 32'h0, 3'b010, 32'hDEAD55EF, 1'b0);
        do_req(1'b0, 32'h23, 32'h0, 3'b101, 32'h00008001, 1'b0);
`endif

        // Reset while in WAIT: no response, store data retained.
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h10;
        req_mask  = 3'b010;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("wait_no_valid", 32'(resp_valid), 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_in_wait_valid", 32'(resp_valid), 32'd0);
        check("rst_in_wait_ready", 32'(req_ready), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("after_rst_valid", 32'(resp_valid), 32'd0);
            check("after_rst_ready", 32'(req_ready), 32'd1);
        end
        do_req(1'b0, 32'h10, 32'h0, 3'b010, 32'hDEAD55EF, 1'b0);

        repeat (3) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_port.md
DMEM_PORT -- requirements
Module: dmem_port

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 64: number of 32-bit words, power of two, at least 4.
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, range 0-15: extra cycles between request accept and response.
REQ-003 SHALL have port clk, input, 1: single clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port req_valid, input, 1: request present.
REQ-006 SHALL have port req_ready, output, 1: block can accept a request.
REQ-007 SHALL have port req_we, input, 1: 1 = store, 0 = load.
REQ-008 SHALL have port req_addr, input, 32: byte address.
REQ-009 SHALL have port req_wdata, input, 32: store data, LSB-aligned.
REQ-010 SHALL have port req_mask, input, 3: RISC-V funct3 size/sign code.
REQ-011 SHALL have port resp_valid, output, 1: response present.
REQ-012 SHALL have port resp_ready, input, 1: consumer accepts response.
REQ-013 SHALL have port resp_rdata, output, 32: load result, sign- or zero-extended; 0 for stores and errors.
REQ-014 SHALL have port resp_err, output, 1: request rejected, no memory side effect.

Function
REQ-015 SHALL be an FSM with states IDLE, WAIT and RESP; req_ready = 1 only in IDLE; only one request outstanding.
REQ-016 SHALL accept a request on a rising edge with req_valid & req_ready, and latch addr, we, wdata and mask.
- Then go to WAIT if WAIT_CYCLES > 0, otherwise to RESP.
REQ-017 SHALL count WAIT_CYCLES cycles in WAIT, then go to RESP; resp_valid therefore rises WAIT_CYCLES+1 edges after accept.
REQ-018 SHALL hold resp_valid, resp_rdata and resp_err stable in RESP until resp_ready = 1, then return to IDLE on that edge.
- No new request is accepted on that same edge.
REQ-019 SHALL decode loads as: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; any other load code gives err = 1.
REQ-020 SHALL decode stores as: 000 SB, 001 SH, 010 SW; any other store code gives err = 1.
REQ-021 SHALL select the byte lane by addr[1:0] and the halfword lane by addr[1].
REQ-022 SHALL, for SB/SH, write only the addressed byte or halfword (taken from wdata[7:0] or wdata[15:0]) and preserve all other bytes of the word.
REQ-023 SHALL commit stores on the accept edge; reads sample the array on the edge entering RESP.
REQ-024 SHALL set err for word index addr[31:2] >= DEPTH_WORDS; an errored store writes nothing.
REQ-025 SHALL initialise the memory array to all zeros at time 0.

Reset
REQ-026 SHALL, while rst_n = 0 at an edge, force state IDLE, the wait counter to 0, resp_valid 0, resp_rdata 0 and resp_err 0.
REQ-027 SHALL drop an in-flight response on reset; a store already committed stays in memory; reset never clears the array.
REQ-028 SHALL drive req_ready 0 during reset and 1 on the first cycle after reset is released.

Configuration
REQ-029 SHALL honour macro DMEM_MISALIGN_TRAP_EN.
- Defined: a halfword access with addr[0] = 1, or a word access with addr[1:0] != 0, gives err = 1, no write, rdata 0.
- Undefined: misaligned low address bits are ignored (LH/SH use addr[1] only, LW/SW use addr[31:2]) and no error is raised.

Structure
REQ-030 SHALL place the following in shared package dmem_pkg: the mem_op_e enum for the funct3 codes, the dmem_state_e FSM enum, and the constant BYTES_PER_WORD = 4.
REQ-031 SHALL use sub-module dmem_lane_align (combinational) for load extract/extend and for store byte-enable plus data insert.

Verification
REQ-032 SHALL check: WAIT_CYCLES=1, SW 0xDEADBEEF @0x10, then LW @0x10 -> resp_valid 2 cycles after each accept; rdata 0xDEADBEEF.
REQ-033 SHALL check: after REQ-032, SB 0x55 @0x11, then LW @0x10 -> 0xDEAD55EF; LB @0x13 -> 0xFFFFFFDE; LBU @0x13 -> 0x000000DE.
REQ-034 SHALL check: SH 0x8001 @0x22, then LH @0x22 -> 0xFFFF8001; LHU @0x22 -> 0x00008001; LW @0x20 -> 0x80010000.
REQ-035 SHALL check: resp_ready held 0 for 5 cycles -> resp_valid and rdata stable and req_ready 0; the response completes on the edge resp_ready rises.
REQ-036 SHALL check: LW @0x100 with DEPTH_WORDS=64 -> err 1, rdata 0; SW mask 011 -> err 1 and memory unchanged.
REQ-037 SHALL check: with DMEM_MISALIGN_TRAP_EN defined, LW @0x12 -> err 1; reset asserted in WAIT -> IDLE next cycle, no response.
